// File: rtl/dither_pkg.sv
// Shared definitions for the 6-input 2-level dither checker: symbol codes,
// local generator register lengths and seed, and the lock FSM states.
package dither_pkg;

    // Two legal dither symbols; the other two codes are invalid.
    localparam logic [1:0] DITH_POS = 2'b01;
    localparam logic [1:0] DITH_NEG = 2'b11;

    // Generator register lengths (s0/s1/s2/s3).
    localparam int S0_LEN = 1;
    localparam int S1_LEN = 4;
    localparam int S2_LEN = 1;
    localparam int S3_LEN = 13;

    // Generator seed applied at reset.
    localparam logic [S0_LEN-1:0] S0_SEED = 1'b1;
    localparam logic [S1_LEN-1:0] S1_SEED = '0;
    localparam logic [S2_LEN-1:0] S2_SEED = '0;
    localparam logic [S3_LEN-1:0] S3_SEED = '0;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } dither_state_e;

    // Symbol expected for a given generator select bit.
    function automatic logic [1:0] dith_sym(input logic sel);
        return sel ? DITH_NEG : DITH_POS;
    endfunction

    // Codes 2'b00 and 2'b10 are not dither symbols (bit 0 clear).
    function automatic logic dith_invalid(input logic [1:0] d);
        return (d[0] == 1'b0);
    endfunction

endpackage

// File: rtl/dither_lfsr6.sv
// Local dither sequence generator. Holds its state unless adv is high;
// sel is the current sample's sign (0 -> +1, 1 -> -1).
module dither_lfsr6
    import dither_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic adv,
    output logic sel
);

    logic [S0_LEN-1:0] s0_q, s0_d;
    logic [S1_LEN-1:0] s1_q, s1_d;
    logic [S2_LEN-1:0] s2_q, s2_d;
    logic [S3_LEN-1:0] s3_q, s3_d;

    assign sel = s3_q[S3_LEN-1];

    // Recurrence: each stage is fed by its predecessor XORed with sel.
    always_comb begin
        s0_d = s0_q;
        s1_d = s1_q;
        s2_d = s2_q;
        s3_d = s3_q;
        if (adv) begin
            s0_d = sel;
            s1_d = {s1_q[S1_LEN-2:0], s0_q[0] ^ sel};
            s2_d = s1_q[S1_LEN-1] ^ sel;
            s3_d = {s3_q[S3_LEN-2:0], s2_q[0] ^ sel};
        end
    end

    // Generator state registers, seeded on reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s0_q <= S0_SEED;
            s1_q <= S1_SEED;
            s2_q <= S2_SEED;
            s3_q <= S3_SEED;
        end else begin
            s0_q <= s0_d;
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

endmodule

// File: rtl/dither_check6.sv
// Receiver-side dither sequence checker. Slips the local generator until it
// lines up with din, declares lock after LOCK_CNT consecutive matches, and
// while locked flags mismatches, dropping lock when UNLOCK_ERR errors land
// inside one WIN-sample window. Flags are one-clk pulses one clk after the
// consuming edge. Optional macro DITHER_CHECK_ERRCNT_EN adds a saturating
// 16-bit err pulse counter (err_cnt) with synchronous clear (err_clr).
module dither_check6
    import dither_pkg::*;
#(
    parameter int LOCK_CNT   = 32,
    parameter int WIN        = 64,
    parameter int UNLOCK_ERR = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       clk_en,
    input  logic [1:0] din,
    output logic       lock,
    output logic       err,
    output logic       slip,
    output logic       inval
`ifdef DITHER_CHECK_ERRCNT_EN
    ,
    input  logic        err_clr,
    output logic [15:0] err_cnt
`endif
);

    localparam int MAX_AB = (LOCK_CNT > WIN) ? LOCK_CNT : WIN;
    localparam int MAX_P  = (MAX_AB > UNLOCK_ERR) ? MAX_AB : UNLOCK_ERR;
    localparam int CNT_W  = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] LOCK_C   = CNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN - 1);
    localparam logic [CNT_W-1:0] UNLOCK_C = CNT_W'(UNLOCK_ERR);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    dither_state_e    state_q, state_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0] ecnt_q, ecnt_d;
    logic [CNT_W-1:0] ecnt_nx;
    logic             lock_q, lock_d;
    logic             err_q, err_d;
    logic             slip_q, slip_d;
    logic             inval_q, inval_d;

    logic             adv;
    logic             sel;
    logic [1:0]       exp_sym;
    logic             is_inval;
    logic             hit;

    dither_lfsr6 u_lfsr (
        .clk  (clk),
        .rstn (rstn),
        .adv  (adv),
        .sel  (sel)
    );

    assign exp_sym  = dith_sym(sel);
    assign is_inval = dith_invalid(din);
    assign hit      = !is_inval && (din == exp_sym);

    assign lock  = lock_q;
    assign err   = err_q;
    assign slip  = slip_q;
    assign inval = inval_q;

    // Acquisition/lock FSM: next state, counters, generator advance, flags.
    always_comb begin
        state_d = state_q;
        mcnt_d  = mcnt_q;
        wcnt_d  = wcnt_q;
        ecnt_d  = ecnt_q;
        ecnt_nx = ecnt_q;
        lock_d  = lock_q;
        err_d   = 1'b0;
        slip_d  = 1'b0;
        inval_d = 1'b0;
        adv     = 1'b0;
        if (clk_en) begin
            inval_d = is_inval;
            case (state_q)
                HUNT: begin
                    if (hit) begin
                        adv     = 1'b1;
                        mcnt_d  = ONE;
                        state_d = VERIFY;
                    end else begin
                        slip_d = 1'b1;
                    end
                end
                VERIFY: begin
                    if (hit) begin
                        adv    = 1'b1;
                        mcnt_d = mcnt_q + ONE;
                        if ((mcnt_q + ONE) >= LOCK_C) begin
                            state_d = LOCKED;
                            lock_d  = 1'b1;
                            wcnt_d  = '0;
                            ecnt_d  = '0;
                        end
                    end else begin
                        slip_d  = 1'b1;
                        mcnt_d  = '0;
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    adv = 1'b1;
                    if (!hit) begin
                        err_d = 1'b1;
                        if (ecnt_q < UNLOCK_C) begin
                            ecnt_nx = ecnt_q + ONE;
                        end
                    end
                    // Threshold takes precedence over a window wrap on the same sample.
                    if (ecnt_nx >= UNLOCK_C) begin
                        state_d = HUNT;
                        lock_d  = 1'b0;
                        mcnt_d  = '0;
                        wcnt_d  = '0;
                        ecnt_d  = '0;
                    end else if (wcnt_q >= WIN_LAST) begin
                        wcnt_d = '0;
                        ecnt_d = '0;
                    end else begin
                        wcnt_d = wcnt_q + ONE;
                        ecnt_d = ecnt_nx;
                    end
                end
                default: begin
                    state_d = HUNT;
                    mcnt_d  = '0;
                    lock_d  = 1'b0;
                end
            endcase
        end
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= HUNT;
            mcnt_q  <= '0;
            wcnt_q  <= '0;
            ecnt_q  <= '0;
            lock_q  <= 1'b0;
            err_q   <= 1'b0;
            slip_q  <= 1'b0;
            inval_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mcnt_q  <= mcnt_d;
            wcnt_q  <= wcnt_d;
            ecnt_q  <= ecnt_d;
            lock_q  <= lock_d;
            err_q   <= err_d;
            slip_q  <= slip_d;
            inval_q <= inval_d;
        end
    end

`ifdef DITHER_CHECK_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    assign err_cnt = err_cnt_q;

    // Saturating err pulse count; clear wins over a same-cycle increment.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (err_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // Error counter register; survives lock loss, cleared only by reset or err_clr.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end
`endif

endmodule
